// File: rtl/pll_phase_sequencer.sv
// Phase-shift sequencer for a PLL reconfig slave: writes mode, DPS and start,
// then polls status until complete or timed out, tracking applied phase.
module pll_phase_sequencer #(
   parameter int TIMEOUT  = 4096,
   parameter int POLL_GAP = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_updn,
   input  logic [4:0]  cmd_cntsel,
   input  logic [15:0] cmd_steps,
   output logic [5:0]  av_address,
   output logic        av_read,
   output logic        av_write,
   output logic [31:0] av_writedata,
   input  logic [31:0] av_readdata,
   input  logic        av_waitrequest,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] phase_acc
);

   typedef enum logic [2:0] {
      IDLE, WR_MODE, WR_DPS, WR_START, RD_STATUS, POLL_WAIT, FINISH
   } state_t;

   localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);
   localparam logic [31:0] GAP_LAST = 32'(POLL_GAP - 1);

   state_t      state_q, state_d;
   logic [31:0] to_q, to_d;
   logic [31:0] gap_q, gap_d;
   logic        updn_q, updn_d;
   logic [4:0]  cntsel_q, cntsel_d;
   logic [15:0] steps_q, steps_d;
   logic [31:0] acc_q, acc_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        rd_unused;

   assign rd_unused = ^av_readdata[31:1];

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= IDLE;
         to_q     <= '0;
         gap_q    <= '0;
         updn_q   <= 1'b0;
         cntsel_q <= '0;
         steps_q  <= '0;
         acc_q    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         to_q     <= to_d;
         gap_q    <= gap_d;
         updn_q   <= updn_d;
         cntsel_q <= cntsel_d;
         steps_q  <= steps_d;
         acc_q    <= acc_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      to_d         = to_q;
      gap_d        = gap_q;
      updn_d       = updn_q;
      cntsel_d     = cntsel_q;
      steps_d      = steps_q;
      acc_d        = acc_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      cmd_ready    = 1'b0;
      av_read      = 1'b0;
      av_write     = 1'b0;
      av_address   = '0;
      av_writedata = '0;
      unique case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               updn_d   = cmd_updn;
               cntsel_d = cmd_cntsel;
               steps_d  = cmd_steps;
               state_d  = (cmd_steps == '0) ? FINISH : WR_MODE;
            end
         end
         WR_MODE: begin
            av_write     = 1'b1;
            av_writedata = 32'h1;
            if (!av_waitrequest) state_d = WR_DPS;
         end
         WR_DPS: begin
            av_write     = 1'b1;
            av_address   = 6'd6;
            av_writedata = {10'b0, updn_q, cntsel_q, steps_q};
            if (!av_waitrequest) state_d = WR_START;
         end
         WR_START: begin
            av_write     = 1'b1;
            av_address   = 6'd2;
            av_writedata = 32'h1;
            if (!av_waitrequest) begin
               state_d = RD_STATUS;
               to_d    = '0;
            end
         end
         RD_STATUS: begin
            av_read    = 1'b1;
            av_address = 6'd1;
            to_d       = to_q + 32'd1;
            // Timeout wins even over a read completing in the same cycle
            if (to_q == TO_LAST) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else if (!av_waitrequest) begin
               gap_d   = '0;
               state_d = av_readdata[0] ? FINISH : POLL_WAIT;
            end
         end
         POLL_WAIT: begin
            to_d  = to_q + 32'd1;
            gap_d = gap_q + 32'd1;
            if (to_q == TO_LAST) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else if (gap_q == GAP_LAST) begin
               state_d = RD_STATUS;
            end
         end
         FINISH: begin
            done_d  = 1'b1;
            state_d = IDLE;
            acc_d   = updn_q ? acc_q + {16'b0, steps_q}
                             : acc_q - {16'b0, steps_q};
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign err       = err_q;
   assign phase_acc = acc_q;

endmodule

// File: tb/tb_pll_phase_sequencer.sv
// Randomized bench for pll_phase_sequencer: Avalon slave model with
// configurable stalls and status sequence, checked against a timing model.
module tb_pll_phase_sequencer;

   localparam int T = 64;
   localparam int G = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_updn;
   logic [4:0]  cmd_cntsel;
   logic [15:0] cmd_steps;
   logic [5:0]  av_address;
   logic        av_read;
   logic        av_write;
   logic [31:0] av_writedata;
   logic [31:0] av_readdata;
   logic        av_waitrequest;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] phase_acc;

   pll_phase_sequencer #(.TIMEOUT(T), .POLL_GAP(G)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_updn(cmd_updn), .cmd_cntsel(cmd_cntsel),
      .cmd_steps(cmd_steps),
      .av_address(av_address), .av_read(av_read),
      .av_write(av_write), .av_writedata(av_writedata),
      .av_readdata(av_readdata),
      .av_waitrequest(av_waitrequest),
      .busy(busy), .done(done), .err(err),
      .phase_acc(phase_acc)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string tag,
                      input logic [63:0] obs,
                      input logic [63:0] exp);
      nvec++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // slave configuration and expectations (written by stimulus only)
   int          w_cfg = 0;
   int          n_cfg = 0;
   bit          started = 0;
   logic [5:0]  ew_a[3];
   logic [31:0] ew_d[3];
   logic [31:0] acc_m = '0;

   // monitor state (written by monitor only)
   int          cyc = 0;
   int          wcnt = 0;
   int          wi = 0;
   int          rd_cnt = 0;
   int          n_done = 0;
   int          n_err = 0;
   int          acc_cyc = 0;
   int          done_cyc = 0;
   int          err_cyc = 0;
   int          last_rd = 0;
   int          last_wr = 0;
   bit          prev_stall = 0;
   logic [5:0]  prev_a = '0;
   logic [31:0] prev_d = '0;

   always @(negedge clk) begin
      cyc++;
      if (av_read || av_write) begin
         if (wcnt < w_cfg) begin
            av_waitrequest = 1'b1;
            wcnt++;
         end else begin
            av_waitrequest = 1'b0;
            wcnt = 0;
         end
      end else begin
         av_waitrequest = 1'b0;
         wcnt = 0;
      end
      av_readdata = {31'($urandom), (rd_cnt >= n_cfg)};
      if (started && reset) begin
         if (cmd_valid && cmd_ready) begin
            rd_cnt = 0; wi = 0; n_done = 0; n_err = 0;
            acc_cyc = cyc;
         end
         if (av_read || av_write)
            chk("excl", 64'(av_read && av_write), 64'd0);
         if (prev_stall && busy)
            chk("wr_stall", {25'b0, av_write, av_address, av_writedata},
                {25'b0, 1'b1, prev_a, prev_d});
         if (av_write && !av_waitrequest) begin
            if (wi < 3) begin
               chk("wr_addr", 64'(av_address), 64'(ew_a[wi]));
               chk("wr_data", 64'(av_writedata), 64'(ew_d[wi]));
            end else begin
               chk("extra_wr", 64'(wi), 64'd2);
            end
            wi++;
            last_wr = cyc;
         end
         if (av_read && !av_waitrequest) begin
            chk("rd_addr", 64'(av_address), 64'd1);
            if (rd_cnt > 0)
               chk("rd_gap", 64'(cyc - last_rd), 64'(w_cfg + 1 + G));
            rd_cnt++;
            last_rd = cyc;
         end
         if (done || err) begin
            chk("done_err", 64'(done && err), 64'd0);
            if (done) begin n_done++; done_cyc = cyc; end
            if (err)  begin n_err++;  err_cyc = cyc;  end
         end
      end
      prev_stall = av_write && av_waitrequest;
      prev_a = av_address;
      prev_d = av_writedata;
   end

   task automatic issue(input logic u, input logic [4:0] cs,
                        input logic [15:0] st);
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_updn = u; cmd_cntsel = cs; cmd_steps = st;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic run_cmd(input logic u, input logic [4:0] cs,
                          input logic [15:0] st, input int w, input int n);
      int  c;
      bit  ok;
      w_cfg = w;
      n_cfg = n;
      ew_a[0] = 6'd0; ew_d[0] = 32'd1;
      ew_a[1] = 6'd6;
      ew_d[1] = 32'(u) * 32'h20_0000 + 32'(cs) * 32'h1_0000 + 32'(st);
      ew_a[2] = 6'd2; ew_d[2] = 32'd1;
      c  = (n + 1) * (w + 1) + n * G - 1;
      ok = (st == 0) || (c < T - 1);
      issue(u, cs, st);
      for (int i = 0; i < 3000; i++) begin
         if (n_done + n_err != 0) break;
         @(posedge clk); #1;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("hang", 64'(n_done + n_err), 64'd1);
      chk("n_done", 64'(n_done), ok ? 64'd1 : 64'd0);
      chk("n_err", 64'(n_err), ok ? 64'd0 : 64'd1);
      if (st == 0) begin
         chk("z_wr", 64'(wi), 64'd0);
         chk("z_rd", 64'(rd_cnt), 64'd0);
         chk("z_lat", 64'(done_cyc - acc_cyc), 64'd2);
      end else begin
         chk("n_wr", 64'(wi), 64'd3);
         if (ok) begin
            chk("n_rd", 64'(rd_cnt), 64'(n + 1));
            chk("d_lat", 64'(done_cyc - last_rd), 64'd2);
         end else begin
            chk("to_lat", 64'(err_cyc - last_wr), 64'(T + 1));
         end
      end
      if (ok) acc_m = u ? acc_m + 32'(st) : acc_m - 32'(st);
      chk("acc", 64'(phase_acc), 64'(acc_m));
      chk("ready", 64'(cmd_ready), 64'd1);
      chk("busy", 64'(busy), 64'd0);
   endtask

   initial begin
      reset = 1'b0;
      cmd_valid = 1'b0; cmd_updn = 1'b0;
      cmd_cntsel = '0; cmd_steps = '0;
      av_waitrequest = 1'b0; av_readdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctl", {59'b0, av_read, av_write, busy, done, err}, 64'd0);
      chk("rst_addr", 64'(av_address), 64'd0);
      chk("rst_wdata", 64'(av_writedata), 64'd0);
      chk("rst_acc", 64'(phase_acc), 64'd0);
      reset = 1'b1;
      started = 1;
      @(posedge clk); #1;
      chk("idle_ready", 64'(cmd_ready), 64'd1);

      run_cmd(1'b1, 5'd2, 16'd5, 0, 0);
      chk("acc_5", 64'(phase_acc), 64'h5);
      run_cmd(1'b0, 5'd0, 16'd8, 4, 0);
      run_cmd(1'b0, 5'd0, 16'd3, 0, 0);
      run_cmd(1'b1, 5'd1, 16'd10, 0, 3);
      run_cmd(1'b1, 5'd7, 16'd9, 0, 1000);
      run_cmd(1'b1, 5'd3, 16'd0, 0, 0);
      run_cmd(1'b0, 5'd4, 16'd1, 3, 4);
      run_cmd(1'b0, 5'd4, 16'd1, 3, 5);

      for (int k = 0; k < 40; k++) begin
         logic [15:0] st;
         int          nn;
         st = ($urandom_range(0, 3) == 0) ? 16'd0
              : 16'($urandom_range(1, 65535));
         nn = $urandom_range(0, 6);
         if (nn == 6) nn = 1000;
         run_cmd(1'($urandom), 5'($urandom), st,
                 $urandom_range(0, 3), nn);
      end

      // reset during a stalled DPS write
      w_cfg = 10;
      n_cfg = 0;
      issue(1'b1, 5'd5, 16'd7);
      for (int i = 0; i < 100; i++) begin
         if (av_write && av_address == 6'd6) break;
         @(posedge clk); #1;
      end
      chk("dps_seen", {57'b0, av_write, av_address}, {57'b0, 1'b1, 6'd6});
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      chk("abort_wr", 64'(av_write), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      acc_m = '0;
      repeat (4) @(posedge clk);
      #1;
      chk("abort_done", 64'(n_done), 64'd0);
      chk("abort_err", 64'(n_err), 64'd0);
      chk("abort_acc", 64'(phase_acc), 64'd0);

      run_cmd(1'b0, 5'd9, 16'd2, 1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
